// File: rtl/ext_int_controller.sv
// External interrupt controller: per-source pending/overrun capture, fixed-priority
// arbitration (bit 0 highest) and a single-level offer/service handshake with the CPU.
module ext_int_controller #(
  parameter int N_SOURCES = 4,
  parameter int ID_W      = $clog2(N_SOURCES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SOURCES-1:0] int_req,
  input  logic [N_SOURCES-1:0] int_mask,
  input  logic                 global_ie,
  output logic                 irq_valid,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ack,
  input  logic                 irq_done,
  output logic                 in_service,
  output logic [N_SOURCES-1:0] pending,
  output logic [N_SOURCES-1:0] overrun,
  input  logic [N_SOURCES-1:0] overrun_clr
);

  // state   | meaning
  // IDLE    | no interrupt outstanding; arbitrate over enabled pending sources
  // OFFER   | irq_valid high, waiting for irq_ack; irq_id frozen
  // SERVICE | handler running, waiting for irq_done; no nesting
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [N_SOURCES-1:0]   pending_q, pending_d;
  logic [N_SOURCES-1:0]   overrun_q, overrun_d;
  logic [N_SOURCES-1:0]   eligible;
  logic [N_SOURCES-1:0]   ack_clr;
  logic [ID_W-1:0]        pick_id;
  logic                   take_ack;

  assign eligible = pending_q & int_mask;
  assign take_ack = (state_q == OFFER) && irq_ack;
  assign ack_clr  = take_ack ? (N_SOURCES'(1) << id_q) : '0;

  // Scan from the top so the lowest index present wins.
  always_comb begin
    pick_id = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_id = ID_W'(i);
      end
    end
  end

  // A request arriving in the same cycle as its clear keeps the flag set.
  always_comb begin
    pending_d = (pending_q & ~ack_clr) | int_req;
    overrun_d = (overrun_q & ~overrun_clr) | (int_req & pending_q & ~ack_clr);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (global_ie && (|eligible)) begin
          state_d = OFFER;
          id_d    = pick_id;
        end
      end
      OFFER: begin
        if (irq_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_valid  = (state_q == OFFER);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = id_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/ext_int_controller.md
EXT_INT_CONTROLLER -- requirements
Module: ext_int_controller

Interface
REQ-001 SHALL have parameter N_SOURCES, default 4, number of interrupt sources (2..16).
REQ-002 SHALL have parameter ID_W, default $clog2(N_SOURCES), width of irq_id.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port int_req  input  N_SOURCES  one-cycle request pulses from per-pin edge handlers, bit i = source i.
REQ-006 SHALL have port int_mask  input  N_SOURCES  per-source enable, 1 = source may be granted.
REQ-007 SHALL have port global_ie  input  1  global interrupt enable from the CPU status register.
REQ-008 SHALL have port irq_valid  output  1  interrupt offered to the CPU.
REQ-009 SHALL have port irq_id  output  ID_W  index of offered/in-service source.
REQ-010 SHALL have port irq_ack  input  1  CPU accepts the offered interrupt (vector fetch).
REQ-011 SHALL have port irq_done  input  1  CPU return-from-interrupt pulse.
REQ-012 SHALL have port in_service  output  1  handler currently executing.
REQ-013 SHALL have port pending  output  N_SOURCES  pending flags, readable by software.
REQ-014 SHALL have port overrun  output  N_SOURCES  sticky lost-request flags.
REQ-015 SHALL have port overrun_clr  input  N_SOURCES  one-cycle clear strobes for overrun bits.

Function
REQ-016 SHALL set pending[i] on the cycle after int_req[i]=1, regardless of int_mask, global_ie or state.
REQ-017 SHALL clear pending[irq_id] on the cycle after irq_ack is sampled with irq_valid=1.
REQ-018 SHALL give set priority: int_req[i] coincident with clear of pending[i] leaves pending[i]=1.
REQ-019 SHALL set overrun[i] when int_req[i]=1 while pending[i]=1 and pending[i] is not being cleared that cycle.
REQ-020 SHALL clear overrun[i] on overrun_clr[i]=1; a coincident set wins.
REQ-021 SHALL implement three states: IDLE, OFFER, SERVICE.
REQ-022 IDLE: SHALL move to OFFER when global_ie=1 and |(pending & int_mask); irq_id loads lowest-index eligible source (fixed priority, bit 0 highest).
REQ-023 OFFER: SHALL drive irq_valid=1, hold irq_id constant; no retraction if mask or global_ie drops.
REQ-024 OFFER: SHALL move to SERVICE on irq_ack=1; irq_valid deasserts the same edge.
REQ-025 SHALL ignore irq_ack outside OFFER and irq_done outside SERVICE.
REQ-026 SERVICE: SHALL drive in_service=1, hold irq_id; no nesting, new requests only accumulate in pending.
REQ-027 SERVICE: SHALL move to IDLE on irq_done=1; re-arbitration occurs in IDLE on the following cycle.
REQ-028 Latency: int_req pulse at edge T (state IDLE, enabled) SHALL yield irq_valid=1 after edge T+2.
REQ-029 irq_valid and in_service SHALL never be 1 simultaneously.
REQ-030 pending and overrun outputs SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-031 On rst_n=0 at a clock edge SHALL force state IDLE, pending=0, overrun=0, irq_valid=0, in_service=0, irq_id=0.
REQ-032 Reset mid-OFFER or mid-SERVICE SHALL abandon the transaction; int_req during reset is discarded.
REQ-033 Outputs SHALL be valid one cycle after rst_n rises; no state held across reset.

Verification
REQ-034 Single: global_ie=1, mask=4'b1111, int_req=4'b0100 one cycle -> pending=4'b0100 at T+1, irq_valid=1 irq_id=2 at T+2; irq_ack -> pending=0, in_service=1; irq_done -> IDLE.
REQ-035 Priority: int_req=4'b1010 same cycle -> irq_id=1 first; after irq_done, irq_id=3 offered two cycles later.
REQ-036 Masking: mask=4'b1110, int_req[0] pulse -> pending[0]=1, irq_valid stays 0; set mask[0]=1 -> irq_valid=1 irq_id=0 next cycle.
REQ-037 Overrun: two int_req[3] pulses with no ack -> overrun[3]=1, pending[3]=1; overrun_clr[3] -> overrun[3]=0; set/clear same cycle -> overrun[3]=1.
REQ-038 Ack/set collision: int_req[2] pulses on the irq_ack cycle for id 2 -> pending[2] stays 1, re-offered after irq_done.
REQ-039 Reset in SERVICE with pending=4'b0011 -> all outputs 0 next cycle; spurious irq_done/irq_ack afterwards produce no change.
